// File: rtl/lane_loader.sv
// Round-robin tile loader: spreads upstream words across LANES downstream buffers,
// tracking free space per lane with credits and zero-padding short tiles.
//   state | meaning
//   IDLE  | waiting for the first word of a tile, lane 0 selected
//   LOAD  | mid-tile, accepting words round-robin
//   PAD   | s_last seen early, writing zeros to the remaining lanes
//   DONE  | final write on lane_wr, tile_done pulses, lane index rewinds
module lane_loader #(
    parameter int WORDLEN = 8,
    parameter int LANES   = 4,
    parameter int BUFSIZE = 10,
    parameter int PADDING = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORDLEN-1:0] s_data,
    input  logic               s_last,
    output logic [LANES-1:0]   lane_wr,
    output logic [WORDLEN-1:0] lane_din,
    input  logic [LANES-1:0]   lane_pop,
    output logic               busy,
    output logic               tile_done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(BUFSIZE) + 1;
    localparam logic [CW-1:0] CRED_INIT = CW'(BUFSIZE - 1 - PADDING);
    localparam logic [CW-1:0] CRED_MAX  = CW'(BUFSIZE - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [LW-1:0]      r_cur_lane;
    logic [LW-1:0]      w_lane_nxt;
    logic [LW-1:0]      w_lane_inc;
    logic [CW-1:0]      r_credit [LANES];
    logic               r_live;
    logic [LANES-1:0]   r_lane_wr;
    logic [WORDLEN-1:0] r_lane_din;
    logic [CW-1:0]      w_cur_credit;
    logic [LANES-1:0]   w_lane_sel;
    logic               w_has_credit;
    logic               w_accept;
    logic               w_pad_wr;
    logic               w_wr;
    logic               w_at_last;

    // Lane select by compare rather than array index keeps LANES=1 legal.
    always_comb begin
        w_cur_credit = '0;
        w_lane_sel   = '0;
        for (int j = 0; j < LANES; j++) begin
            if (r_cur_lane == LW'(j)) begin
                w_lane_sel[j] = 1'b1;
                w_cur_credit  = r_credit[j];
            end
        end
    end

    assign w_has_credit = (w_cur_credit != '0);
    // r_live holds s_ready low until the first clock edge after reset release.
    assign s_ready      = r_live && ((r_state == IDLE) || (r_state == LOAD)) && w_has_credit;
    assign w_accept     = s_valid && s_ready;
    assign w_pad_wr     = (r_state == PAD) && w_has_credit;
    assign w_wr         = w_accept || w_pad_wr;
    assign w_at_last    = (r_cur_lane == LAST_LANE);
    assign w_lane_inc   = w_at_last ? '0 : r_cur_lane + LW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_cur_lane;
        case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    w_lane_nxt = w_lane_inc;
                    if (s_last) begin
                        w_state_nxt = w_at_last ? DONE : PAD;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            PAD: begin
                if (w_pad_wr) begin
                    w_lane_nxt  = w_lane_inc;
                    w_state_nxt = w_at_last ? DONE : PAD;
                end
            end
            DONE: begin
                w_lane_nxt  = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_lane_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cur_lane <= '0;
            r_live     <= 1'b0;
            r_lane_wr  <= '0;
            r_lane_din <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_lane <= w_lane_nxt;
            r_live     <= 1'b1;
            r_lane_wr  <= w_wr ? w_lane_sel : '0;
            if (w_accept) begin
                r_lane_din <= s_data;
            end else if (w_pad_wr) begin
                r_lane_din <= '0;
            end
        end
    end

    // A write and a pop on the same lane cancel; pops beyond full are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < LANES; j++) begin
                r_credit[j] <= CRED_INIT;
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if (w_wr && w_lane_sel[j] && !lane_pop[j]) begin
                    r_credit[j] <= r_credit[j] - CW'(1);
                end else if (!(w_wr && w_lane_sel[j]) && lane_pop[j] && (r_credit[j] != CRED_MAX)) begin
                    r_credit[j] <= r_credit[j] + CW'(1);
                end
            end
        end
    end

    assign lane_wr   = r_lane_wr;
    assign lane_din  = r_lane_din;
    assign busy      = (r_state == LOAD) || (r_state == PAD);
    assign tile_done = (r_state == DONE);

endmodule

// File: tb/tb_lane_loader.sv
// Scoreboard bench for lane_loader: a tile-level reference model predicts every
// lane write and s_ready; a negedge monitor pops expectations as writes appear.
module tb_lane_loader;
    localparam int L = 4;
    localparam int B = 10;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [W-1:0] s_data = '0;
    logic [L-1:0] lane_pop = '0;
    logic         s_ready, busy, tile_done;
    logic [L-1:0] lane_wr;
    logic [W-1:0] lane_din;

    logic         pv = 1'b0, plast = 1'b0;
    logic [W-1:0] pd = '0;
    logic [L-1:0] ppop = '0;
    logic         prdy, pbusy, pdone;
    logic [L-1:0] pwr;
    logic [W-1:0] pdin;

    logic         ov = 1'b0, olast = 1'b0;
    logic [W-1:0] od = '0;
    logic [0:0]   opop = '0;
    logic         ordy, obusy, odone;
    logic [0:0]   owr;
    logic [W-1:0] odin;

    always #5 clk = ~clk;

    lane_loader #(.WORDLEN(W), .LANES(L), .BUFSIZE(B), .PADDING(0)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .lane_wr(lane_wr), .lane_din(lane_din), .lane_pop(lane_pop),
        .busy(busy), .tile_done(tile_done));

    lane_loader #(.WORDLEN(W), .LANES(L), .BUFSIZE(B), .PADDING(3)) u_pad (
        .clk(clk), .rstn(rstn), .s_valid(pv), .s_ready(prdy), .s_data(pd),
        .s_last(plast), .lane_wr(pwr), .lane_din(pdin), .lane_pop(ppop),
        .busy(pbusy), .tile_done(pdone));

    lane_loader #(.WORDLEN(W), .LANES(1), .BUFSIZE(B), .PADDING(0)) u_one (
        .clk(clk), .rstn(rstn), .s_valid(ov), .s_ready(ordy), .s_data(od),
        .s_last(olast), .lane_wr(owr), .lane_din(odin), .lane_pop(opop),
        .busy(obusy), .tile_done(odone));

    typedef struct {
        logic [L-1:0] wr;
        logic [W-1:0] din;
        logic         done;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_pass = 0, n_total = 0, n_wr = 0, n_done = 0;
    logic [W-1:0] hold_din = '0;

    // Reference model: credits per lane, next lane index, and tile phase
    // (0 accepting words, 1 padding, 2 final-write cycle).
    int           m_cred[L];
    int           m_k, m_mode;
    bit           m_intile, m_live, m_acc;
    int           t_left;
    logic [W-1:0] t_data;
    bit           t_rand;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int j = 0; j < L; j++) m_cred[j] = B - 1;
        m_k = 0; m_mode = 0; m_intile = 0; m_live = 0; m_acc = 0;
    endtask

    task automatic push(input int lane, input logic [W-1:0] d, input bit done);
        exp_t e;
        e.wr = '0;
        e.wr[lane] = 1'b1;
        e.din = d;
        e.done = done;
        q.push_back(e);
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit last, input logic [L-1:0] pop);
        bit rdy;
        int wl;
        @(negedge clk);
        #1;
        s_valid = v; s_data = d; s_last = last; lane_pop = pop;
        rdy = m_live && (m_mode == 0) && (m_cred[m_k] > 0);
        chk("s_ready", 64'(s_ready), 64'(rdy));
        chk("busy", 64'(busy), 64'((m_mode == 1) || (m_mode == 0 && m_intile)));
        m_acc = v && rdy;
        wl = -1;
        case (m_mode)
            0: if (m_acc) begin
                wl = m_k;
                push(m_k, d, last && (m_k == L - 1));
                if (last) begin
                    m_intile = 0;
                    m_mode = (m_k == L - 1) ? 2 : 1;
                    m_k = (m_k + 1) % L;
                end else begin
                    m_intile = 1;
                    m_k = (m_k + 1) % L;
                end
            end
            1: if (m_cred[m_k] > 0) begin
                wl = m_k;
                push(m_k, '0, m_k == L - 1);
                if (m_k == L - 1) m_mode = 2;
                else m_k++;
            end
            default: begin m_mode = 0; m_k = 0; end
        endcase
        for (int j = 0; j < L; j++) begin
            if (wl == j && !pop[j]) m_cred[j]--;
            else if (wl != j && pop[j] && m_cred[j] < B - 1) m_cred[j]++;
        end
        m_live = 1;
    endtask

    task automatic feed(input int cycles, input int vpct, input logic [L-1:0] popmask, input int ppct);
        for (int c = 0; c < cycles; c++) begin
            bit v;
            logic [L-1:0] p;
            v = (t_left > 0) && ($urandom_range(0, 99) < vpct);
            for (int j = 0; j < L; j++) p[j] = popmask[j] && ($urandom_range(0, 99) < ppct);
            step(v, t_data, t_left == 1, p);
            if (m_acc) begin
                t_left--;
                t_data = t_rand ? W'($urandom) : t_data + 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            hold_din = '0;
        end
        if (lane_wr !== '0 || tile_done !== 1'b0) begin
            if (q.size() == 0) begin
                chk("spurious_wr", 64'({tile_done, lane_wr}), 64'(0));
            end else begin
                mon_e = q.pop_front();
                chk("lane_wr", 64'(lane_wr), 64'(mon_e.wr));
                chk("lane_din", 64'(lane_din), 64'(mon_e.din));
                chk("tile_done", 64'(tile_done), 64'(mon_e.done));
                hold_din = mon_e.din;
                n_wr++;
                if (tile_done) n_done++;
            end
        end else begin
            chk("din_hold", 64'(lane_din), 64'(hold_din));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, bdone, ptot, p0;
        rstn = 1'b0;
        model_reset();
        t_left = 0; t_data = '0; t_rand = 0;
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_lane_wr", 64'(lane_wr), 64'(0));
        chk("rst_lane_din", 64'(lane_din), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tile_done", 64'(tile_done), 64'(0));
        repeat (2) @(posedge clk);
        #2 chk("rst_s_ready_clk", 64'(s_ready), 64'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        chk("ready_at_release", 64'(s_ready), 64'(0));

        // Eight words, last on lane 3: two full rounds, no padding.
        base = n_wr; bdone = n_done;
        t_left = 8; t_data = 8'd1; t_rand = 0;
        feed(12, 100, '0, 0);
        chk("full_tile_writes", 64'(n_wr - base), 64'(8));
        chk("full_tile_done", 64'(n_done - bdone), 64'(1));

        // Six words: lanes 2 and 3 get zero padding.
        base = n_wr; bdone = n_done;
        t_left = 6; t_data = 8'd1;
        feed(10, 100, '0, 0);
        chk("pad_tile_writes", 64'(n_wr - base), 64'(8));
        chk("pad_tile_done", 64'(n_done - bdone), 64'(1));

        // Refill credits, then run every lane dry.
        feed(12, 0, '1, 100);
        base = n_wr;
        t_left = 40; t_data = 8'd1;
        feed(45, 100, '0, 0);
        chk("credit_exhaust", 64'(n_wr - base), 64'(36));
        chk("stall_ready", 64'(s_ready), 64'(0));
        feed(1, 100, 4'b0001, 100);
        feed(4, 100, '0, 0);
        chk("one_pop_one_word", 64'(n_wr - base), 64'(37));
        feed(30, 100, '1, 100);
        chk("exhaust_tile_end", 64'(t_left), 64'(0));

        for (int t = 0; t < 80; t++) begin
            t_left = $urandom_range(1, 10);
            t_data = W'($urandom);
            t_rand = 1;
            for (int c = 0; c < 300 && t_left > 0; c++) feed(1, 70, '1, 30);
            chk("tile_finished", 64'(t_left), 64'(0));
            feed($urandom_range(0, 3), 0, '1, 30);
        end
        feed(L + 2, 0, '1, 30);

        // Asynchronous reset in the middle of padding.
        feed(12, 0, '1, 100);
        t_left = 2; t_data = 8'h11; t_rand = 0;
        for (int c = 0; c < 10 && m_mode != 1; c++) feed(1, 100, '0, 0);
        @(posedge clk);
        #2 chk("busy_in_pad", 64'(busy), 64'(1));
        rstn = 1'b0;
        #1;
        chk("async_s_ready", 64'(s_ready), 64'(0));
        chk("async_lane_wr", 64'(lane_wr), 64'(0));
        chk("async_lane_din", 64'(lane_din), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_tile_done", 64'(tile_done), 64'(0));
        model_reset();
        t_left = 0;
        s_valid = 0; lane_pop = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("ready_at_release2", 64'(s_ready), 64'(0));
        feed(6, 0, '0, 0);

        // PADDING=3: six credits per lane, so lane 0 stalls on its seventh word.
        ptot = 0; p0 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ptot += $countones(pwr);
            p0 += int'(pwr[0]);
            #1 pv = 1'b1; pd = W'(c);
        end
        chk("pad3_total", 64'(ptot), 64'(24));
        chk("pad3_lane0", 64'(p0), 64'(6));
        chk("pad3_stall", 64'(prdy), 64'(0));
        pv = 1'b0;

        // Single lane: s_last goes straight to DONE.
        @(negedge clk);
        #1 chk("one_ready", 64'(ordy), 64'(1));
        ov = 1'b1; od = 8'hA5; olast = 1'b1;
        @(negedge clk);
        #1 ov = 1'b0; olast = 1'b0;
        chk("one_wr", 64'(owr), 64'(1));
        chk("one_din", 64'(odin), 64'(8'hA5));
        chk("one_done", 64'(odone), 64'(1));
        chk("one_busy", 64'(obusy), 64'(0));
        @(negedge clk);
        #1 chk("one_wr_after", 64'(owr), 64'(0));
        chk("one_done_after", 64'(odone), 64'(0));
        chk("one_ready_after", 64'(ordy), 64'(1));

        @(negedge clk);
        #1 chk("queue_empty", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
